// File: rtl/timer_bank.sv
// Multi-channel programmable down-counter bank. Channels share one prescaler.
// Each channel has a one-shot or auto-reload mode, an expiry pulse and a sticky flag.

module timer_chan #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             load_periodic,
  input  logic             decr,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] count,
  output logic             expire,
  output logic             flag
);

  logic [WIDTH-1:0] reload;
  logic             periodic;
  logic             step;
  logic             last;

  // A load in the same cycle swallows the decrement, so it can never expire.
  assign step = !load && tick && decr && (count != '0);
  assign last = step && (count == WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      reload   <= '0;
      periodic <= 1'b0;
      expire   <= 1'b0;
      flag     <= 1'b0;
    end else begin
      expire <= last;
      flag   <= last | (flag & ~flag_clr);
      if (load) begin
        count    <= load_value;
        reload   <= load_value;
        periodic <= load_periodic;
      end else if (step) begin
        count <= last ? (periodic ? reload : '0) : count - WIDTH'(1);
      end
    end
  end

endmodule

module timer_bank #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int CH_W       = 2,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  load_en,
  input  logic [CH_W-1:0]       load_ch,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  load_periodic,
  input  logic [CHANNELS-1:0]   decr,
  input  logic [CHANNELS-1:0]   flag_clr,
  input  logic [CH_W-1:0]       rd_ch,
  output logic [WIDTH-1:0]      rd_count,
  output logic [CHANNELS-1:0]   timeup,
  output logic [CHANNELS-1:0]   expire,
  output logic [CHANNELS-1:0]   flag,
  output logic                  irq
);

  logic [PRESCALE_W-1:0]           pcnt;
  logic                            tick;
  logic [CHANNELS-1:0][WIDTH-1:0]  count;

  // >= rather than == so lowering prescale below pcnt ticks at once instead of wrapping.
  assign tick = (pcnt >= prescale);

  always_ff @(posedge clk) begin
    if (reset) pcnt <= '0;
    else       pcnt <= tick ? '0 : pcnt + PRESCALE_W'(1);
  end

  // Out-of-range load_ch matches no instance, so the write is dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    timer_chan #(.WIDTH(WIDTH)) u_ch (
      .clk           (clk),
      .reset         (reset),
      .tick          (tick),
      .load          (load_en && (load_ch == CH_W'(i))),
      .load_value    (load_value),
      .load_periodic (load_periodic),
      .decr          (decr[i]),
      .flag_clr      (flag_clr[i]),
      .count         (count[i]),
      .expire        (expire[i]),
      .flag          (flag[i])
    );
    assign timeup[i] = (count[i] == '0);
  end

  always_comb begin
    rd_count = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (rd_ch == CH_W'(i)) rd_count = count[i];
  end

  assign irq = |flag;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: a behavioural model checked every cycle plus
// hand-computed literal expectations for each scenario.

module tb_timer_bank;

  localparam int W   = 8;
  localparam int NCH = 4;
  localparam int CHW = 3;
  localparam int PW  = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [PW-1:0]  prescale;
  logic           load_en;
  logic [CHW-1:0] load_ch;
  logic [W-1:0]   load_value;
  logic           load_periodic;
  logic [NCH-1:0] decr;
  logic [NCH-1:0] flag_clr;
  logic [CHW-1:0] rd_ch;
  logic [W-1:0]   rd_count;
  logic [NCH-1:0] timeup;
  logic [NCH-1:0] expire;
  logic [NCH-1:0] flag;
  logic           irq;

  always #5 clk = ~clk;

  timer_bank #(.WIDTH(W), .CHANNELS(NCH), .CH_W(CHW), .PRESCALE_W(PW)) dut (
    .clk           (clk),
    .reset         (reset),
    .prescale      (prescale),
    .load_en       (load_en),
    .load_ch       (load_ch),
    .load_value    (load_value),
    .load_periodic (load_periodic),
    .decr          (decr),
    .flag_clr      (flag_clr),
    .rd_ch         (rd_ch),
    .rd_count      (rd_count),
    .timeup        (timeup),
    .expire        (expire),
    .flag          (flag),
    .irq           (irq)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: counts as integers, ticks from an integer prescale counter.
  int             m_cnt [NCH];
  int             m_rel [NCH];
  bit             m_per [NCH];
  logic [NCH-1:0] m_exp;
  logic [NCH-1:0] m_flag;
  int             m_pcnt;
  bit             m_tick;
  bit             m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] = 0; m_rel[i] = 0; m_per[i] = 1'b0;
      end
      m_exp = '0; m_flag = '0; m_pcnt = 0; m_valid = 1'b1;
    end else begin
      m_tick = (m_pcnt >= int'(prescale));
      m_pcnt = m_tick ? 0 : m_pcnt + 1;
      for (int i = 0; i < NCH; i++) begin
        m_exp[i] = 1'b0;
        if (load_en && int'(load_ch) == i) begin
          m_cnt[i] = int'(load_value); m_rel[i] = int'(load_value); m_per[i] = load_periodic;
        end else if (m_tick && decr[i] && m_cnt[i] > 0) begin
          if (m_cnt[i] == 1) begin
            m_exp[i] = 1'b1;
            m_cnt[i] = m_per[i] ? m_rel[i] : 0;
          end else begin
            m_cnt[i] = m_cnt[i] - 1;
          end
        end
        m_flag[i] = m_exp[i] | (m_flag[i] & ~flag_clr[i]);
      end
    end
  end

  logic [W-1:0]   e_rd;
  logic [NCH-1:0] e_tu;

  always @(negedge clk) begin
    if (m_valid) begin
      e_rd = '0;
      for (int i = 0; i < NCH; i++) begin
        if (int'(rd_ch) == i) e_rd = W'(m_cnt[i]);
        e_tu[i] = (m_cnt[i] == 0);
      end
      chk("model_rd_count", 32'(rd_count), 32'(e_rd));
      chk("model_timeup",   32'(timeup),   32'(e_tu));
      chk("model_expire",   32'(expire),   32'(m_exp));
      chk("model_flag",     32'(flag),     32'(m_flag));
      chk("model_irq",      32'(irq),      32'(|m_flag));
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  int         exp_c3 [12] = '{2, 2, 1, 1, 1, 2, 2, 2, 1, 1, 1, 2};
  logic [11:0] exp_e3     = 12'b1000_0010_0000; // bit k = pulse after edge k+1

  initial begin
    reset = 1'b1; prescale = '0; load_en = 1'b0; load_ch = '0; load_value = '0;
    load_periodic = 1'b0; decr = '0; flag_clr = '0; rd_ch = '0;
    cyc(); cyc();
    reset = 1'b0;

    // Reset state
    for (int r = 0; r < 8; r++) begin
      rd_ch = CHW'(r); #1;
      chk("rst_rd_count", 32'(rd_count), 0);
    end
    chk("rst_timeup", 32'(timeup), 32'hF);
    chk("rst_expire", 32'(expire), 0);
    chk("rst_flag",   32'(flag),   0);
    chk("rst_irq",    32'(irq),    0);

    // One-shot ch1 = 3, tick every cycle
    cyc();
    rd_ch = 3'd1; load_ch = 3'd1; load_value = 8'd3; load_periodic = 1'b0; load_en = 1'b1;
    decr = 4'b0010;
    cyc(); load_en = 1'b0;
    neg(); chk("os_cnt3", 32'(rd_count), 3); chk("os_noexp", 32'(expire), 0);
    cyc(); neg(); chk("os_cnt2", 32'(rd_count), 2);
    cyc(); neg(); chk("os_cnt1", 32'(rd_count), 1);
    cyc(); neg();
    chk("os_cnt0", 32'(rd_count), 0); chk("os_expire", 32'(expire), 32'h2);
    chk("os_flag", 32'(flag), 32'h2); chk("os_irq", 32'(irq), 1);
    cyc(); neg(); chk("os_hold0", 32'(rd_count), 0); chk("os_single_pulse", 32'(expire), 0);
    cyc(); neg(); chk("os_no_wrap", 32'(rd_count), 0); chk("os_flag_sticky", 32'(flag), 32'h2);
    flag_clr = 4'b0010;
    cyc(); flag_clr = '0; decr = '0;
    neg(); chk("os_flag_clr", 32'(flag), 0); chk("os_irq_clr", 32'(irq), 0);

    // Periodic ch0 = 2 with prescale = 2 (pcnt is 0 here)
    prescale = 4'd2; rd_ch = 3'd0; load_ch = 3'd0; load_value = 8'd2; load_periodic = 1'b1;
    load_en = 1'b1; decr = 4'b0001;
    cyc(); load_en = 1'b0;
    for (int k = 0; k < 12; k++) begin
      neg();
      chk("per_cnt",    32'(rd_count),  32'(exp_c3[k]));
      chk("per_expire", 32'(expire[0]), 32'(exp_e3[k]));
      chk("per_timeup", 32'(timeup[0]), 0);
      cyc();
    end
    decr = '0;

    // Load beats a due decrement; zero load; out-of-range writes
    prescale = '0; rd_ch = 3'd2; load_ch = 3'd2; load_value = 8'd1; load_periodic = 1'b0;
    load_en = 1'b1;
    cyc(); load_en = 1'b0;
    neg(); chk("ld_cnt1", 32'(rd_count), 1);
    load_value = 8'd5; load_en = 1'b1; decr = 4'b0100;
    cyc(); load_en = 1'b0; decr = '0;
    neg(); chk("ld_prio_cnt", 32'(rd_count), 5); chk("ld_prio_noexp", 32'(expire), 0);
    load_value = 8'd0; load_en = 1'b1;
    cyc(); load_en = 1'b0;
    neg(); chk("ld0_timeup", 32'(timeup[2]), 1); chk("ld0_noexp", 32'(expire), 0);
    load_ch = 3'd5; load_value = 8'd9; load_en = 1'b1;
    cyc(); load_ch = 3'd4;
    cyc(); load_en = 1'b0;
    neg(); chk("oor_timeup", 32'(timeup), 32'hE);
    rd_ch = 3'd0; #1; chk("oor_ch0", 32'(rd_count), 2);
    rd_ch = 3'd4; #1; chk("oor_rd4", 32'(rd_count), 0);
    rd_ch = 3'd5; #1; chk("oor_rd5", 32'(rd_count), 0);

    // Expiry and flag_clr in the same cycle on ch3
    cyc();
    rd_ch = 3'd3; load_ch = 3'd3; load_value = 8'd2; load_periodic = 1'b0; load_en = 1'b1;
    decr = 4'b1000;
    cyc(); load_en = 1'b0;
    cyc(); flag_clr = 4'b1000;
    cyc(); flag_clr = '0;
    neg(); chk("sc_expire", 32'(expire), 32'h8); chk("sc_set_wins", 32'(flag[3]), 1);
    chk("sc_cnt", 32'(rd_count), 0);
    flag_clr = 4'b1000;
    cyc(); flag_clr = '0; decr = '0;
    neg(); chk("sc_flags", 32'(flag), 32'h1);

    // Reset mid-count, then prescaler restarts from 0
    prescale = 4'd3; rd_ch = 3'd0; load_ch = 3'd0; load_value = 8'd7; load_periodic = 1'b0;
    load_en = 1'b1; decr = 4'b0001;
    cyc(); load_en = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    cyc(); reset = 1'b0;
    neg();
    chk("mr_cnt", 32'(rd_count), 0); chk("mr_flag", 32'(flag), 0);
    chk("mr_expire", 32'(expire), 0); chk("mr_irq", 32'(irq), 0);
    chk("mr_timeup", 32'(timeup), 32'hF);
    load_en = 1'b1;
    cyc(); load_en = 1'b0;
    neg(); chk("ps_e1", 32'(rd_count), 7);
    cyc(); neg(); chk("ps_e2", 32'(rd_count), 7);
    cyc(); neg(); chk("ps_e3", 32'(rd_count), 7);
    cyc(); neg(); chk("ps_e4", 32'(rd_count), 6);
    cyc(); neg(); chk("ps_e5", 32'(rd_count), 6);
    cyc(); neg(); chk("ps_e6", 32'(rd_count), 6);
    prescale = 4'd1; // below current pcnt of 2: immediate tick
    cyc(); neg(); chk("ps_lower", 32'(rd_count), 5);
    cyc(); neg(); chk("ps_e8", 32'(rd_count), 5);
    cyc(); neg(); chk("ps_e9", 32'(rd_count), 4);
    decr = '0;
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
